pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, two-entry skid buffering, flush and a stall counter. It is the general-purpose successor to the fixed 20-bit IF/ID latch. It sits between any two stages of the pipelined processor (IF/ID, ID/EX, …) and carries an instruction word plus its opcode. It lets a downstream stall back-pressure the upstream stage without losing an instruction, and lets a taken branch squash in-flight contents.

## Interface
- INSTR_W, 20, instruction word width
- OPCODE_W, 4, opcode width
- CNT_W, 16, stall counter width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous squash of held contents
- in_valid  in  1  upstream presents a word
- in_ready  out  1  block can accept a word
- opcode  in  OPCODE_W  opcode of the presented word
- instruction  in  INSTR_W  presented instruction word
- out_valid  out  1  data_out/opcode_out hold a valid word
- out_ready  in  1  downstream consumes the word
- data_out  out  INSTR_W  held instruction
- opcode_out  out  OPCODE_W  held opcode
- instr_passthru  out  INSTR_W  combinational copy of instruction, for same-cycle decode/hazard logic
- occupancy  out  2  number of held words (0..2)
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main register (drives data_out/opcode_out, flag out_valid) and skid register (flag skid_valid).
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = ~skid_valid, registered. It never depends combinationally on out_ready.
- States are encoded by occupancy:
  - EMPTY (0)
    - accept → ONE, main←input.
  - ONE (1)
    - accept & fire → ONE, main←input.
    - accept & ~fire → FULL, skid←input.
    - ~accept & fire → EMPTY.
    - neither → hold.
  - FULL (2), in_ready=0
    - fire → ONE, main←skid, skid cleared.
    - ~fire → hold.
- Empty main register drives the NOP bubble: data_out=0, opcode_out=0. The same applies after a fire that leaves the block EMPTY.
- Skid register contents are zeroed whenever skid_valid clears.
- Word order is strictly FIFO. No word is dropped or duplicated except by flush or reset.
- flush:
  - Forces EMPTY and zeroes main and skid.
  - A word accepted in the flush cycle is discarded. Upstream sees the handshake complete, and the word is squashed.
  - A fire in the flush cycle still counts as consumed by downstream.
- stall_count:
  - Increments by 1 in each cycle with out_valid & ~out_ready.
  - Saturates at all ones, with no wrap.
  - Cleared only by reset. flush does not clear it.
- Priority: reset > flush > normal handshake.
- instr_passthru = instruction at all times, including during reset.

## Timing
- Reset values:
  - out_valid=0, data_out=0, opcode_out=0, occupancy=0, stall_count=0.
  - in_ready=1 from the first edge after reset deasserts. in_ready is also 1 while reset is held.
- Reset mid-operation: all held words are lost at that edge and no output glitches afterwards.
- Latency: a word accepted at edge N appears on data_out/opcode_out with out_valid=1 after edge N, which is 1 cycle.
- Throughput: 1 word/cycle while out_ready=1 continuously.
- Backpressure:
  - With out_ready low, at most 2 words are absorbed.
  - in_ready falls one edge after the second accept.
  - in_ready rises one edge after the fire that empties skid.
- Simultaneous events:
  - FULL + fire + in_valid: no accept, because in_ready=0 that cycle.
  - ONE + accept + fire: main updated, occupancy stays 1.
- occupancy, out_valid and in_ready are all registered and mutually consistent:
  - out_valid = (occupancy≠0)
  - in_ready = (occupancy≠2)

## Test plan
- Reset then stream 0x00001, 0x00002, 0x00003 with opcode 1, 2, 3 and out_ready=1 → each word appears 1 cycle after accept, in order, with occupancy=1 throughout and stall_count=0.
- Accept 0xAAAAA with out_ready=0, then 0x55555 → occupancy=2 and in_ready=0. A third word 0x12345 is held off. Raise out_ready → outputs 0xAAAAA, 0x55555, 0x12345 in order with no loss. stall_count equals the held cycles.
- In FULL state assert flush with in_valid=1 and instruction=0xFFFFF → next cycle occupancy=0, out_valid=0, data_out=0, opcode_out=0. 0xFFFFF never appears, and stall_count is unchanged.
- Hold out_valid=1, out_ready=0 for 2^CNT_W+5 cycles, using CNT_W=4 in that build → stall_count saturates at 15 and does not wrap.
- Assert reset while FULL with stall_count=7 → at the next edge all outputs are at reset values and in_ready=1.
- Drive random instruction values → instr_passthru equals instruction every cycle, including during reset and flush.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream word/valid/ready,
// downstream held word/valid/ready, plus the observability outputs.
interface pipe_stage_reg_if #(
    parameter int INSTR_W  = 20,
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [INSTR_W-1:0]  instruction;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  data_out;
    logic [OPCODE_W-1:0] opcode_out;
    logic [INSTR_W-1:0]  instr_passthru;
    logic [1:0]          occupancy;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output in_valid, opcode, instruction, out_ready,
        input  in_ready, out_valid, data_out, opcode_out,
               instr_passthru, occupancy, stall_count
    );

    modport slave (
        input  in_valid, opcode, instruction, out_ready,
        output in_ready, out_valid, data_out, opcode_out,
               instr_passthru, occupancy, stall_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer, flush squash and a
// saturating stall counter; in_ready is registered so it never depends on out_ready.
module pipe_stage_reg #(
    parameter int INSTR_W  = 20,
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input logic           clock,
    input logic           reset,
    input logic           flush,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_e                state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                main_valid_q, main_valid_d;
    logic [INSTR_W-1:0]  main_data_q, main_data_d;
    logic [OPCODE_W-1:0] main_op_q, main_op_d;
    logic                skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0]  skid_data_q, skid_data_d;
    logic [OPCODE_W-1:0] skid_op_q, skid_op_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept_s;
    logic                fire_s;

    // Next-state for storage, occupancy and stall counter
    always_comb begin
        accept_s     = bus.in_valid & in_ready_q;
        fire_s       = main_valid_q & bus.out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_op_d    = main_op_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_op_d    = skid_op_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = {INSTR_W{1'b0}};
            main_op_d    = {OPCODE_W{1'b0}};
            skid_valid_d = 1'b0;
            skid_data_d  = {INSTR_W{1'b0}};
            skid_op_d    = {OPCODE_W{1'b0}};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_valid_d = 1'b1;
                        main_data_d  = bus.instruction;
                        main_op_d    = bus.opcode;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                ONE: begin
                    case ({accept_s, fire_s})
                        2'b11: begin
                            main_data_d = bus.instruction;
                            main_op_d   = bus.opcode;
                        end
                        2'b10: begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = bus.instruction;
                            skid_op_d    = bus.opcode;
                        end
                        // Consumed with nothing behind it: drive the NOP bubble
                        2'b01: begin
                            main_valid_d = 1'b0;
                            main_data_d  = {INSTR_W{1'b0}};
                            main_op_d    = {OPCODE_W{1'b0}};
                        end
                        default: begin
                            main_valid_d = 1'b1;
                        end
                    endcase
                end
                FULL: begin
                    if (fire_s) begin
                        main_data_d  = skid_data_q;
                        main_op_d    = skid_op_q;
                        skid_valid_d = 1'b0;
                        skid_data_d  = {INSTR_W{1'b0}};
                        skid_op_d    = {OPCODE_W{1'b0}};
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    main_data_d  = {INSTR_W{1'b0}};
                    main_op_d    = {OPCODE_W{1'b0}};
                    skid_valid_d = 1'b0;
                    skid_data_d  = {INSTR_W{1'b0}};
                    skid_op_d    = {OPCODE_W{1'b0}};
                end
            endcase
        end

        if (skid_valid_d) begin
            state_d = FULL;
        end else if (main_valid_d) begin
            state_d = ONE;
        end else begin
            state_d = EMPTY;
        end
        in_ready_d = ~skid_valid_d;

        if (main_valid_q && !bus.out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
            main_data_q  <= {INSTR_W{1'b0}};
            main_op_q    <= {OPCODE_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {INSTR_W{1'b0}};
            skid_op_q    <= {OPCODE_W{1'b0}};
            stall_q      <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_op_q    <= main_op_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_op_q    <= skid_op_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = main_valid_q;
    assign bus.data_out       = main_data_q;
    assign bus.opcode_out     = main_op_q;
    assign bus.occupancy      = state_q;
    assign bus.stall_count    = stall_q;
    assign bus.instr_passthru = bus.instruction;
endmodule
